// File: rtl/la_dmux_sched_pkg.sv
// la_dmux_sched_pkg: index helpers shared by the scheduler and its picker
package la_dmux_sched_pkg;
   function automatic int wrap_add(input int a, input int b, input int n);
      return (a + b >= n) ? a + b - n : a + b;
   endfunction
endpackage

// File: rtl/la_dmux_sched_rrpick.sv
// la_rrpick: combinational rotate-priority picker, first set req at or above ptr (mod N)
module la_rrpick
   import la_dmux_sched_pkg::*;
#(
   parameter int    N    = 4,
   parameter string PROP = "DEFAULT"
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic                 any
);
   assign any = |req;
   if (PROP == "DEFAULT") begin : g_scan
      logic found;
      always_comb begin
         gnt   = '0;
         found = 1'b0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (!found && req[j] && j == wrap_add(int'(ptr), i, N)) begin
                  gnt[j] = 1'b1;
                  found  = 1'b1;
               end
      end
   end else begin : g_rot
      // rotate req down by ptr, isolate lowest set bit, rotate back up
      logic [2*N-1:0] dbl, back;
      logic [N-1:0]   low;
      assign dbl  = {req, req} >> ptr;
      assign low  = dbl[N-1:0] & (~dbl[N-1:0] + 1'b1);
      assign back = {low, low} << ptr;
      assign gnt  = back[2*N-1:N];
   end
endmodule

// File: rtl/la_dmux_sched.sv
// la_dmux_sched: round-robin one-hot select scheduler for a shared dmux with optional packet lock
module la_dmux_sched
   import la_dmux_sched_pkg::*;
#(
   parameter int    N    = 4,
   parameter int    HOLD = 1,
   parameter string PROP = "DEFAULT"
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic [N-1:0] last,
   output logic [N-1:0] in_ready,
   output logic [N-1:0] sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);
   localparam int   PW    = $clog2(N);
   localparam logic IDLE  = 1'b0;
   localparam logic GRANT = 1'b1;
   logic          state_q, state_d;
   logic [N-1:0]  sel_q, sel_d, gnt;
   logic [PW-1:0] ptr_q, ptr_d, nxt_ptr;
   logic          any, xfer, rel, upd;
   la_rrpick #(.N(N), .PROP(PROP)) u_pick (
      .req(req),
      .ptr(ptr_d),
      .gnt(gnt),
      .any(any)
   );
   always_comb begin
      nxt_ptr = '0;
      for (int i = 0; i < N; i++)
         if (sel_q[i]) nxt_ptr = PW'(wrap_add(i, 1, N));
   end
   assign out_valid = |(sel_q & req);
   assign in_ready  = sel_q & {N{out_ready}};
   assign xfer      = out_valid & out_ready;
   assign rel       = (state_q == GRANT) & xfer & ((|(sel_q & last)) | (HOLD == 0));
   assign upd       = (state_q == IDLE) | rel;
   // release rotates the pointer first so the same-cycle re-arbitration sees g as lowest priority
   always_comb begin
      ptr_d   = rel ? nxt_ptr : ptr_q;
      state_d = upd ? (any ? GRANT : IDLE) : state_q;
      sel_d   = upd ? gnt : sel_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end
   assign sel  = sel_q;
   assign busy = (state_q == GRANT);
endmodule
